// File: rtl/pe_arr_pkg.sv
// Shared types and helpers for the PE array result-drain path.
package pe_arr_pkg;

    localparam int ACC_W_DEFAULT = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // A single-beat frame still needs a one-bit beat index port.
    function automatic int beat_width(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/pe_arr_drain_mux.sv
// Selects the LANES words of one output beat from the captured snapshot.
module pe_arr_drain_mux
    import pe_arr_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEFAULT,
    parameter int LANES  = 4,
    parameter int NBEATS = 4,
    parameter int BEAT_W = beat_width(NBEATS)
) (
    input  logic [0:NBEATS*LANES*ACC_W-1] snapshot,
    input  logic [BEAT_W-1:0]             beat,
    output logic [0:LANES*ACC_W-1]        data
);

    localparam int BEAT_BITS = LANES * ACC_W;

    always_comb begin
        data = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (beat == BEAT_W'(b)) begin
                data = snapshot[b*BEAT_BITS +: BEAT_BITS];
            end
        end
    end

endmodule

// File: rtl/pe_arr_drain.sv
// Snapshots the PE array accumulators on start and streams them out as
// LANES-word beats over valid/ready, freeing the array immediately.
module pe_arr_drain
    import pe_arr_pkg::*;
#(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int LANES = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [0:ROWS*COLS*ACC_W-1]              in_res_port,
    output logic                                    busy,
    output logic [0:LANES*ACC_W-1]                  out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_last,
    output logic [beat_width(ROWS*COLS/LANES)-1:0]  out_beat,
    output logic                                    done
);

    localparam int                NBEATS    = ROWS * COLS / LANES;
    localparam int                BEAT_W    = beat_width(NBEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    generate
        if ((ROWS * COLS) % LANES != 0) begin : g_bad_lanes
            $error("pe_arr_drain: ROWS*COLS must be a multiple of LANES");
        end
    endgenerate

    drain_state_t                 state, state_next;
    logic [0:ROWS*COLS*ACC_W-1]   snapshot;
    logic [BEAT_W-1:0]            beat_q, beat_next;
    logic                         done_next;
    logic                         capture;
    logic [0:LANES*ACC_W-1]       mux_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            beat_q <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            beat_q <= beat_next;
            done   <= done_next;
        end
    end

    // Snapshot contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (capture) begin
            snapshot <= in_res_port;
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat_q;
        done_next  = 1'b0;
        capture    = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                capture    = 1'b1;
                beat_next  = '0;
                state_next = STREAM;
            end
        end else if (out_ready) begin
            if (beat_q == LAST_BEAT) begin
                state_next = IDLE;
                beat_next  = '0;
                done_next  = 1'b1;
            end else begin
                beat_next = beat_q + 1'b1;
            end
        end
    end

    pe_arr_drain_mux #(
        .ACC_W  (ACC_W),
        .LANES  (LANES),
        .NBEATS (NBEATS),
        .BEAT_W (BEAT_W)
    ) u_mux (
        .snapshot (snapshot),
        .beat     (beat_q),
        .data     (mux_data)
    );

    // Payload is forced to zero outside STREAM so reset and idle look clean.
    assign busy      = (state == STREAM);
    assign out_valid = (state == STREAM);
    assign out_last  = (state == STREAM) && (beat_q == LAST_BEAT);
    assign out_beat  = beat_q;
    assign out_data  = (state == STREAM) ? mux_data : '0;

endmodule

// File: tb/tb_pe_arr_drain.sv
// Scoreboard bench for pe_arr_drain: a 4x4/4-lane instance for streaming
// behaviour and a 2x2/4-lane instance for the single-beat frame case.
module tb_pe_arr_drain;

    localparam int ACC_W = 32;
    localparam int LANES = 4;
    localparam int N_A   = 16;
    localparam int NB_A  = 4;
    localparam int N_B   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                     start_a, ready_a;
    logic [0:N_A*ACC_W-1]     res_a;
    logic                     busy_a, valid_a, last_a, done_a;
    logic [0:LANES*ACC_W-1]   data_a;
    logic [1:0]               beat_a;

    logic                     start_b, ready_b;
    logic [0:N_B*ACC_W-1]     res_b;
    logic                     busy_b, valid_b, last_b, done_b;
    logic [0:LANES*ACC_W-1]   data_b;
    logic [0:0]               beat_b;

    pe_arr_drain #(.ROWS(4), .COLS(4), .ACC_W(ACC_W), .LANES(LANES)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .in_res_port (res_a),
        .busy        (busy_a),
        .out_data    (data_a),
        .out_valid   (valid_a),
        .out_ready   (ready_a),
        .out_last    (last_a),
        .out_beat    (beat_a),
        .done        (done_a)
    );

    pe_arr_drain #(.ROWS(2), .COLS(2), .ACC_W(ACC_W), .LANES(LANES)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .in_res_port (res_b),
        .busy        (busy_b),
        .out_data    (data_b),
        .out_valid   (valid_b),
        .out_ready   (ready_b),
        .out_last    (last_b),
        .out_beat    (beat_b),
        .done        (done_b)
    );

    typedef struct {
        logic [0:LANES*ACC_W-1] data;
        logic [1:0]             beat;
        logic                   last;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] words[N_A];
    logic        model_busy = 1'b0;
    logic        exp_done   = 1'b0;
    int          total = 0;
    int          bad   = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setWords(input logic [31:0] base);
        for (int e = 0; e < N_A; e++) words[e] = base + 32'(e);
    endtask

    function automatic logic [0:N_A*ACC_W-1] packWords();
        logic [0:N_A*ACC_W-1] v;
        for (int e = 0; e < N_A; e++) v[e*ACC_W +: ACC_W] = words[e];
        return v;
    endfunction

    // Observed outputs must match the model, and the head of the scoreboard
    // every cycle the frame is live (which also proves hold-stability).
    task automatic checkState();
        checkOutput("busy", 128'(busy_a), 128'(model_busy));
        checkOutput("valid", 128'(valid_a), 128'(model_busy));
        checkOutput("done", 128'(done_a), 128'(exp_done));
        if (model_busy && sb.size() > 0) begin
            checkOutput("data", data_a, sb[0].data);
            checkOutput("beat", 128'(beat_a), 128'(sb[0].beat));
            checkOutput("last", 128'(last_a), 128'(sb[0].last));
        end else if (!model_busy) begin
            checkOutput("idle_beat", 128'(beat_a), 128'd0);
            checkOutput("idle_last", 128'(last_a), 128'd0);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic rs);
        logic  nb, nd;
        beat_t t;
        checkState();
        start_a = st;
        ready_a = rdy;
        rst     = rs;
        res_a   = packWords();
        nb = model_busy;
        nd = 1'b0;
        if (rs) begin
            nb = 1'b0;
            sb.delete();
        end else begin
            if (model_busy && rdy) begin
                void'(sb.pop_front());
                if (sb.size() == 0) begin
                    nb = 1'b0;
                    nd = 1'b1;
                end
            end
            if (!model_busy && st) begin
                for (int b = 0; b < NB_A; b++) begin
                    for (int k = 0; k < LANES; k++) t.data[k*ACC_W +: ACC_W] = words[b*LANES+k];
                    t.beat = 2'(b);
                    t.last = (b == NB_A - 1);
                    sb.push_back(t);
                end
                nb = 1'b1;
            end
        end
        @(negedge clk);
        model_busy = nb;
        exp_done   = nd;
    endtask

    task automatic drain();
        int n = 0;
        while ((model_busy || exp_done) && n < 40) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("drain_timeout", 128'(model_busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic pat[8];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1; start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
        setWords(32'h1000);
        res_a = packWords();
        res_b = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_data", data_a, 128'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] frame with ready held high");
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain();

        $display("[TB] frame with toggling ready");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, pat[i], 1'b0);
        drain();

        $display("[TB] input changes after capture");
        applyStimulus(1'b1, 1'b1, 1'b0);
        setWords(32'hDEAD_0000);
        drain();
        setWords(32'h1000);

        $display("[TB] start ignored mid-frame, accepted in done cycle");
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        setWords(32'h3000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("done_cycle", 128'(exp_done), 128'd1);
        setWords(32'h2000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain();

        $display("[TB] reset mid-frame");
        setWords(32'h1000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        setWords(32'h4000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        drain();

        $display("[TB] single-beat frame");
        for (int e = 0; e < N_B; e++) res_b[e*ACC_W +: ACC_W] = 32'hB000 + 32'(e);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        res_b   = '0;
        checkOutput("b_valid", 128'(valid_b), 128'd1);
        checkOutput("b_busy", 128'(busy_b), 128'd1);
        checkOutput("b_last", 128'(last_b), 128'd1);
        checkOutput("b_beat", 128'(beat_b), 128'd0);
        checkOutput("b_data", data_b, 128'h0000B000_0000B001_0000B002_0000B003);
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
        checkOutput("b_done", 128'(done_b), 128'd1);
        checkOutput("b_valid_after", 128'(valid_b), 128'd0);
        checkOutput("b_busy_after", 128'(busy_b), 128'd0);
        @(negedge clk);
        checkOutput("b_done_pulse", 128'(done_b), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
